// File: rtl/display_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared types and constants for the 8-digit 7-segment display scan controller.
//   digit_t        - one BCD/hex digit (one nibble of the 32-bit digit word)
//   scan_state_t   - scan FSM states: display off, anti-ghost guard, anode on
//   MAX_DIGITS     - physical digit count of the display (width of anodes)
//   anode_onehot() - active-high one-hot anode pattern for a digit index
// -----------------------------------------------------------------------------
package display_pkg;

  typedef logic [3:0] digit_t;

  typedef enum logic [1:0] {
    S_OFF,
    S_GUARD,
    S_ON
  } scan_state_t;

  localparam int MAX_DIGITS = 8;

  function automatic logic [MAX_DIGITS-1:0] anode_onehot(input logic [2:0] sel);
    anode_onehot      = '0;
    anode_onehot[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl_if
// Bundles the producer handshake and the display-side outputs of the scan
// controller.
//   enable      - 1 = scan, 0 = display off (driven by master)
//   digits_in   - new 32-bit digit word, nibble i = digit i (driven by master)
//   load_valid  - producer offers digits_in (driven by master)
//   load_ready  - controller accepts digits_in this cycle (driven by slave)
//   digits_out  - shadow digit word for the digit mux (driven by slave)
//   digit_sel   - current slot index, digit mux select (driven by slave)
//   anodes      - active-low one-hot anode enables (driven by slave)
//   frame_tick  - 1-cycle pulse at the end of the last slot (driven by slave)
// Modports: master = producer/consumer side, slave = the controller.
// -----------------------------------------------------------------------------
interface display_scan_ctrl_if;
  import display_pkg::*;

  logic                  enable;
  logic [31:0]           digits_in;
  logic                  load_valid;
  logic                  load_ready;
  logic [31:0]           digits_out;
  logic [2:0]            digit_sel;
  logic [MAX_DIGITS-1:0] anodes;
  logic                  frame_tick;

  modport master (
    output enable, digits_in, load_valid,
    input  load_ready, digits_out, digit_sel, anodes, frame_tick
  );

  modport slave (
    input  enable, digits_in, load_valid,
    output load_ready, digits_out, digit_sel, anodes, frame_tick
  );

endinterface

// File: rtl/display_scan_ctrl_prescaler.sv
// -----------------------------------------------------------------------------
// scan_prescaler
// Slot timer for the display scan. Down-counter that reloads to REFRESH_DIV-1;
// the counter value is the number of cycles left in the current slot, so the
// elapsed count within the slot is REFRESH_DIV-1-cnt.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clr         - restart the slot (elapsed count 0 in the next cycle)
//   tc          - last cycle of the slot (elapsed == REFRESH_DIV-1)
//   guard_last  - last cycle of the guard window (elapsed == GUARD_CYCLES-1)
// Requires GUARD_CYCLES >= 1 and REFRESH_DIV >= GUARD_CYCLES+2.
// -----------------------------------------------------------------------------
module scan_prescaler #(
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tc,
  output logic guard_last
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LOAD_VAL       = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_LAST_VAL = CW'(REFRESH_DIV - GUARD_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q - CW'(1);
    if (clr || (cnt_q == '0)) begin
      cnt_d = LOAD_VAL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= LOAD_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc         = (cnt_q == '0);
  assign guard_last = (cnt_q == GUARD_LAST_VAL);

endmodule

// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
// Time-division scan scheduler for the 8-digit 7-segment display. Each digit
// gets a slot of REFRESH_DIV cycles; the first GUARD_CYCLES of every slot keep
// all anodes dark to avoid ghosting. The digit word shown is a shadow copy that
// only changes at frame boundaries (or immediately while the display is off),
// so a frame never mixes old and new digits.
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset
//   bus    - display_scan_ctrl_if.slave (enable, load handshake, digit word,
//            digit_sel, anodes, frame_tick)
// Parameters: REFRESH_DIV, GUARD_CYCLES, NUM_DIGITS (1..8, unused anodes high).
// Build option: define DISPLAY_LZB_EN for leading-zero blanking (digit i>0
// stays dark while it and every more significant digit is zero).
// -----------------------------------------------------------------------------
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 8,
  parameter int NUM_DIGITS   = 8
) (
  input logic                clk,
  input logic                rst_n,
  display_scan_ctrl_if.slave bus
);

  scan_state_t           state_q, state_d;
  logic [2:0]            sel_q, sel_d;
  logic                  pend_full_q, pend_full_d;
  logic [31:0]           pend_q, pend_d;
  logic [31:0]           digits_q, digits_d;

  logic                  presc_clr;
  logic                  tc;
  logic                  guard_last;
  logic                  slot_end;
  logic                  last_slot;
  logic                  frame_end;
  logic                  load_ready;
  logic                  accept;
  logic                  transfer;
  logic [MAX_DIGITS-1:0] lit_mask;
  logic [MAX_DIGITS-1:0] anode_en;

  // Slot timer is held at the slot start whenever the display is off or about
  // to switch off, so a restart always begins with a full guard window.
  assign presc_clr = !bus.enable || (state_q == S_OFF);

  scan_prescaler #(
    .REFRESH_DIV  (REFRESH_DIV),
    .GUARD_CYCLES (GUARD_CYCLES)
  ) u_prescaler (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (presc_clr),
    .tc         (tc),
    .guard_last (guard_last)
  );

  assign slot_end  = tc && (state_q == S_ON);
  assign last_slot = (sel_q == 3'(NUM_DIGITS - 1));
  assign frame_end = slot_end && last_slot;

  // ---------------------------------------------------------------------------
  // Scan FSM and digit counter
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    if (!bus.enable) begin
      state_d = S_OFF;
      sel_d   = 3'd0;
    end else begin
      unique case (state_q)
        S_OFF: begin
          state_d = S_GUARD;
          sel_d   = 3'd0;
        end
        S_GUARD: begin
          if (guard_last) begin
            state_d = S_ON;
          end
        end
        S_ON: begin
          if (tc) begin
            state_d = S_GUARD;
            sel_d   = last_slot ? 3'd0 : sel_q + 3'd1;
          end
        end
        default: begin
          state_d = S_OFF;
          sel_d   = 3'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Load path: one pending word, copied to the shadow register at frame end.
  // While off nothing is being scanned, so the copy happens straight away.
  // At frame end the pending slot frees up in the same cycle, which is why a
  // new word can be accepted in the frame_tick cycle.
  // ---------------------------------------------------------------------------
  assign load_ready = !pend_full_q || frame_end;
  assign accept     = bus.load_valid && load_ready;
  assign transfer   = pend_full_q && (frame_end || (state_q == S_OFF));

  always_comb begin
    digits_d    = digits_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    if (transfer) begin
      digits_d    = pend_q;
      pend_full_d = 1'b0;
    end
    if (accept) begin
      pend_d      = bus.digits_in;
      pend_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_OFF;
      sel_q       <= 3'd0;
      pend_full_q <= 1'b0;
      pend_q      <= '0;
      digits_q    <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      pend_full_q <= pend_full_d;
      pend_q      <= pend_d;
      digits_q    <= digits_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-digit lit mask. Digits beyond NUM_DIGITS never light.
  // ---------------------------------------------------------------------------
`ifdef DISPLAY_LZB_EN
  // upper_nz[i] = some digit in i..NUM_DIGITS-1 is non-zero
  logic [MAX_DIGITS:0] upper_nz;
  assign upper_nz[MAX_DIGITS] = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < MAX_DIGITS; gi++) begin : g_lit
      if (gi >= NUM_DIGITS) begin : g_unused
        assign lit_mask[gi] = 1'b0;
`ifdef DISPLAY_LZB_EN
        assign upper_nz[gi] = 1'b0;
`endif
      end else begin : g_used
`ifdef DISPLAY_LZB_EN
        digit_t nib;
        assign nib          = digits_q[4*gi +: 4];
        assign upper_nz[gi] = (nib != 4'h0) || upper_nz[gi+1];
        if (gi == 0) begin : g_lsd
          assign lit_mask[gi] = 1'b1;
        end else begin : g_blank
          assign lit_mask[gi] = upper_nz[gi];
        end
`else
        assign lit_mask[gi] = 1'b1;
`endif
      end
    end
  endgenerate

  // Anodes decode directly from the registered state/select, so they follow
  // the FSM with no extra lag. Blanked digits still occupy their slot.
  assign anode_en = (state_q == S_ON) ? (anode_onehot(sel_q) & lit_mask) : '0;

  assign bus.anodes     = ~anode_en;
  assign bus.digit_sel  = sel_q;
  assign bus.digits_out = digits_q;
  assign bus.frame_tick = frame_end;
  assign bus.load_ready = load_ready;

endmodule
